// File: rtl/uart_tx_if.sv
// Handshake bundle between a UART transmitter and its client: baud tick,
// start request and parallel data in; serial line and status flags out.
interface uart_tx_if #(
  parameter int data_wd = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [data_wd-1:0] i_din;
  logic               o_tx;
  logic               o_tx_busy;
  logic               o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_din,
    input  o_tx, o_tx_busy, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_din,
    output o_tx, o_tx_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), paced by a
// shared oversampling tick. Define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx #(
  parameter int BAUD              = 9600,
  parameter int clk_freq          = 50_000_000,
  parameter int oversampling_rate = 16,
  parameter int data_wd           = 8,
  parameter int parity            = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int TW = $clog2(oversampling_rate);
  localparam int BW = $clog2(data_wd + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(oversampling_rate - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(data_wd - 1);
  localparam bit            HAS_PARITY = (parity == 1) || (parity == 2);

  if (oversampling_rate < 2 || clk_freq < BAUD * oversampling_rate) begin : g_cfg_check
    $error("uart_tx: oversampling_rate must be >= 2 and clk_freq >= BAUD*oversampling_rate");
  end

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t             r_state;
  logic [data_wd-1:0] r_shift;
  logic               r_par_bit;
  logic [TW-1:0]      r_tick_count;
  logic [BW-1:0]      r_bit_index;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;
`ifdef UART_TX_TWO_STOP_EN
  logic               r_stop_second;
`endif

  logic               w_in_bit;
  logic               w_bit_end;
  logic [data_wd-1:0] w_shift_next;

  assign w_in_bit     = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_bit_end    = w_in_bit && bus.i_tick && (r_tick_count == TICK_LAST);
  assign w_shift_next = r_shift >> 1;

  // NOTE: all state updates use <= so every register samples pre-edge values;
  // the async reset returns the line high the moment rst rises, even mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_par_bit     <= 1'b0;
      r_tick_count  <= '0;
      r_bit_index   <= '0;
      r_tx          <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_second <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_in_bit && bus.i_tick)
        r_tick_count <= w_bit_end ? '0 : r_tick_count + TW'(1);

      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (bus.i_tx_start) begin
            r_shift      <= bus.i_din;
            r_par_bit    <= (parity == 2) ? ^bus.i_din : ~^bus.i_din;
            r_tick_count <= '0;
            r_bit_index  <= '0;
            r_busy       <= 1'b1;
            r_tx         <= 1'b0;
            r_state      <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_index <= '0;
            r_tx        <= r_shift[0];
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift     <= w_shift_next;
            r_bit_index <= r_bit_index + BW'(1);
            if (r_bit_index != BIT_LAST) begin
              r_tx <= w_shift_next[0];
            end else if (HAS_PARITY) begin
              r_tx    <= r_par_bit;
              r_state <= S_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
            // The first stop-bit boundary only arms the flag; the second ends the frame.
            if (!r_stop_second) begin
              r_stop_second <= 1'b1;
            end else begin
              r_stop_second <= 1'b0;
              r_done        <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= S_DONE;
            end
`else
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx      = r_tx;
  assign bus.o_tx_busy = r_busy;
  assign bus.o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (odd, even, no parity) share one stimulus
// stream; each frame is sampled mid-bit and compared with hand-derived bit patterns.
module tb_uart_tx;

  localparam int OSR = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       tx_start;
  logic [7:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.data_wd(8)) if_odd  ();
  uart_tx_if #(.data_wd(8)) if_even ();
  uart_tx_if #(.data_wd(8)) if_none ();

  assign if_odd.i_tick      = tick;
  assign if_odd.i_tx_start  = tx_start;
  assign if_odd.i_din       = din;
  assign if_even.i_tick     = tick;
  assign if_even.i_tx_start = tx_start;
  assign if_even.i_din      = din;
  assign if_none.i_tick     = tick;
  assign if_none.i_tx_start = tx_start;
  assign if_none.i_din      = din;

  uart_tx #(.oversampling_rate(OSR), .data_wd(8), .parity(1)) dut_odd (
    .clk(clk), .rst(rst), .bus(if_odd.slave));
  uart_tx #(.oversampling_rate(OSR), .data_wd(8), .parity(2)) dut_even (
    .clk(clk), .rst(rst), .bus(if_even.slave));
  uart_tx #(.oversampling_rate(OSR), .data_wd(8), .parity(0)) dut_none (
    .clk(clk), .rst(rst), .bus(if_none.slave));

  // Index 0 = odd parity, 1 = even parity, 2 = no parity.
  logic [2:0] w_tx, w_busy, w_done;
  assign w_tx   = {if_none.o_tx,      if_even.o_tx,      if_odd.o_tx};
  assign w_busy = {if_none.o_tx_busy, if_even.o_tx_busy, if_odd.o_tx_busy};
  assign w_done = {if_none.o_tx_done, if_even.o_tx_done, if_odd.o_tx_done};

  // Sends one frame on all three instances and checks every bit, the frame length and the
  // single done pulse. p_odd/p_even are the hand-computed parity bits for data.
  task automatic run_frame(input string name, input logic [7:0] data, input logic p_odd,
                           input logic p_even, input int repulse_at, input bit hold);
    logic cap [3][12];
    logic exp_bits [12];
    int   done_tick [3];
    int   done_cnt [3];
    int   nbits;
    for (int d = 0; d < 3; d++) begin
      done_tick[d] = 0;
      done_cnt[d]  = 0;
      for (int b = 0; b < 12; b++) cap[d][b] = 1'bx;
    end
    // NOTE: bench drives inputs with blocking assignments on the falling edge so the
    // DUT samples settled values on the next rising edge.
    @(negedge clk);
    din      = data;
    tx_start = 1'b1;
    @(negedge clk);
    if (!hold) tx_start = 1'b0;
    din = ~data;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({w_busy[d], w_tx[d]} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s accept dut%0d: busy,tx=%b required 10", name, d, {w_busy[d], w_tx[d]});
      end
    end
    for (int t = 1; t <= 200; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (t % OSR == OSR / 2) cap[d][t / OSR] = w_tx[d];
        if (w_done[d]) begin
          done_cnt[d]++;
          if (done_tick[d] == 0) done_tick[d] = t;
        end
      end
      if (t == repulse_at) begin
        tx_start = 1'b1;
        din      = 8'hFF;
      end
      @(negedge clk);
      if (t == repulse_at) begin
        tx_start = 1'b0;
        din      = ~data;
      end
      for (int d = 0; d < 3; d++) if (w_done[d]) done_cnt[d]++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (w_done[d]) done_cnt[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      nbits = 1 + 8 + ((d == 2) ? 0 : 1) + N_STOP;
      for (int b = 0; b < 12; b++) exp_bits[b] = 1'b1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
      if (d == 0) exp_bits[9] = p_odd;
      if (d == 1) exp_bits[9] = p_even;
      for (int b = 0; b < nbits; b++) begin
        n_checks++;
        if (cap[d][b] !== exp_bits[b]) begin
          n_fail++;
          $display("FAIL %s dut%0d bit%0d: tx=%b required %b", name, d, b, cap[d][b], exp_bits[b]);
        end
      end
      n_checks++;
      if (done_tick[d] != nbits * OSR) begin
        n_fail++;
        $display("FAIL %s dut%0d frame length: done at tick %0d required %0d",
                 name, d, done_tick[d], nbits * OSR);
      end
      n_checks++;
      if (done_cnt[d] != 1) begin
        n_fail++;
        $display("FAIL %s dut%0d done pulses: %0d clk required 1", name, d, done_cnt[d]);
      end
      if (!hold) begin
        n_checks++;
        if ({w_tx[d], w_busy[d], w_done[d]} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s dut%0d idle after frame: tx,busy,done=%b required 100",
                   name, d, {w_tx[d], w_busy[d], w_done[d]});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tick     = 1'b0;
    tx_start = 1'b0;
    din      = 8'h00;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({w_tx[d], w_busy[d], w_done[d]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset dut%0d: tx,busy,done=%b required 100", d, {w_tx[d], w_busy[d], w_done[d]});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick = (c % 4 == 0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if ({w_tx[d], w_busy[d], w_done[d]} !== 3'b100) begin
          n_fail++;
          $display("FAIL idle clk%0d dut%0d: tx,busy,done=%b required 100",
                   c, d, {w_tx[d], w_busy[d], w_done[d]});
        end
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_parity_frames();
    // A5 has four ones: odd P=1, even P=0. 07 has three ones: odd P=0, even P=1.
    run_frame("A5", 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    run_frame("07", 8'h07, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_ignore_mid_frame();
    run_frame("A5 repulse", 8'hA5, 1'b1, 1'b0, 60, 1'b0);
    run_frame("FF", 8'hFF, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    din      = 8'hA5;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    // Tick 68 sits in frame bit 4, i.e. data bit 3 of A5, which is 0.
    for (int t = 1; t <= 68; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if ({w_tx, w_busy} !== 6'b000_111) begin
      n_fail++;
      $display("FAIL pre-reset data bit3: tx,busy=%b required 000111", {w_tx, w_busy});
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({w_tx, w_busy, w_done} !== 9'b111_000_000) begin
      n_fail++;
      $display("FAIL async reset mid-frame: tx,busy,done=%b required 111000000", {w_tx, w_busy, w_done});
    end
    @(negedge clk);
    rst = 1'b0;
    // 5A has four ones: odd P=1, even P=0.
    run_frame("5A after rst", 8'h5A, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // 00: odd P=1, even P=0; tx_start stays high so each instance re-arms after DONE.
    run_frame("00 held", 8'h00, 1'b1, 1'b0, 0, 1'b1);
    n_checks++;
    if (w_busy !== 3'b111) begin
      n_fail++;
      $display("FAIL re-arm busy: %b required 111", w_busy);
    end
    tx_start = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
    end
    n_checks++;
    if ({w_tx, w_busy, w_done} !== 9'b111_000_000) begin
      n_fail++;
      $display("FAIL idle after re-armed frame: tx,busy,done=%b required 111000000",
               {w_tx, w_busy, w_done});
    end
  endtask

  initial begin
    test_reset();
    test_parity_frames();
    test_ignore_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
